// File: rtl/nes_pad_responder_if.sv
// Pad-side signal bundle: NES strobe/clock/data lines, pad button state and read status.
interface nes_pad_responder_if;
    logic       joy_strobe;
    logic       joy_clock;
    logic       joy_data;
    logic [7:0] buttons;
    logic [3:0] bit_count;
    logic       read_done;
    logic       latched;

    // Console/pad-state side: drives the NES lines and button state, observes the responder.
    modport master (
        output joy_strobe,
        output joy_clock,
        output buttons,
        input  joy_data,
        input  bit_count,
        input  read_done,
        input  latched
    );

    // Responder side.
    modport slave (
        input  joy_strobe,
        input  joy_clock,
        input  buttons,
        output joy_data,
        output bit_count,
        output read_done,
        output latched
    );
endinterface

// File: rtl/nes_pad_responder.sv
// NES controller responder: synchronizes and debounces strobe/clock from the console,
// latches the button state and shifts it out active-low, one bit per joy_clock rising edge.
module nes_pad_responder #(
    parameter int unsigned FILTER = 3
) (
    input  logic                 clock,
    input  logic                 reset_n,
    nes_pad_responder_if.slave   pad
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned SR_W  = 8;
    localparam int unsigned NCH   = 2;

    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILTER - 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(SR_W - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // Channel 0 = strobe, channel 1 = joy_clock.
    logic [NCH-1:0]   sync_a;
    logic [NCH-1:0]   sync_b;
    logic [NCH-1:0]   filt;
    logic [CNT_W-1:0] filt_cnt [NCH];
    logic             jclk_d;

    logic             strb_f_c;
    logic             jclk_rise_c;

    logic [1:0]       state,     state_n;
    logic [SR_W-1:0]  shreg,     shreg_n;
    logic [CNT_W-1:0] bit_cnt,   bit_cnt_n;
    logic             data_q,    data_n;
    logic             done_q,    done_n;
    logic             latched_q, latched_n;

    // Two-flop synchronizers for the asynchronous NES lines.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {pad.joy_clock, pad.joy_strobe};
            sync_b <= sync_a;
        end
    end

    // Stability filter: output follows input only after FILTER consecutive differing cycles.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            filt <= '0;
            for (int i = 0; i < NCH; i++) filt_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (sync_b[i] != filt[i]) begin
                    if (filt_cnt[i] == FILT_LAST) begin
                        filt[i]     <= sync_b[i];
                        filt_cnt[i] <= '0;
                    end else begin
                        filt_cnt[i] <= CNT_W'(filt_cnt[i] + 1'b1);
                    end
                end else begin
                    filt_cnt[i] <= '0;
                end
            end
        end
    end

    // Delayed filtered joy_clock for rising-edge detection.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) jclk_d <= 1'b0;
        else          jclk_d <= filt[1];
    end

    assign strb_f_c    = filt[0];
    assign jclk_rise_c = filt[1] & ~jclk_d;

    // State, shift register and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            data_q    <= 1'b1;
            done_q    <= 1'b0;
            latched_q <= 1'b0;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            bit_cnt   <= bit_cnt_n;
            data_q    <= data_n;
            done_q    <= done_n;
            latched_q <= latched_n;
        end
    end

    // Next-state logic; a high strobe overrides everything, including a coincident clock edge.
    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        data_n    = data_q;
        done_n    = 1'b0;
        latched_n = latched_q;
        if (strb_f_c) begin
            state_n   = LOAD;
            shreg_n   = pad.buttons;
            bit_cnt_n = '0;
            data_n    = ~pad.buttons[0];
        end else begin
            case (state)
                IDLE: begin
                    data_n = 1'b1;
                end
                LOAD: begin
                    state_n   = SHIFT;
                    latched_n = 1'b1;
                    shreg_n   = pad.buttons;
                    bit_cnt_n = '0;
                    data_n    = ~pad.buttons[0];
                end
                SHIFT: begin
                    if (jclk_rise_c) begin
                        shreg_n   = {1'b0, shreg[SR_W-1:1]};
                        bit_cnt_n = CNT_W'(bit_cnt + 1'b1);
                        data_n    = ~shreg[1];
                        if (bit_cnt == LAST_BIT) begin
                            state_n = DONE;
                            done_n  = 1'b1;
                        end
                    end else begin
                        data_n = ~shreg[0];
                    end
                end
                DONE: begin
                    data_n = ~shreg[0];
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    assign pad.joy_data  = data_q;
    assign pad.bit_count = bit_cnt;
    assign pad.read_done = done_q;
    assign pad.latched   = latched_q;

endmodule

// File: tb/tb_nes_pad_responder.sv
// Directed bench for nes_pad_responder with FILTER = 3.
module tb_nes_pad_responder;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   done_cnt;

    nes_pad_responder_if pad_if ();

    nes_pad_responder #(.FILTER(3)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .pad     (pad_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count read_done high cycles.
    always @(negedge clk) if (pad_if.read_done === 1'b1) done_cnt++;

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe_pulse();
        pad_if.joy_strobe = 1'b1;
        wait_cyc(8);
        pad_if.joy_strobe = 1'b0;
        wait_cyc(8);
    endtask

    task automatic clk_pulse();
        pad_if.joy_clock = 1'b1;
        wait_cyc(7);
        pad_if.joy_clock = 1'b0;
        wait_cyc(6);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pad_if.joy_strobe = 1'b0;
        pad_if.joy_clock  = 1'b0;
        pad_if.buttons    = 8'h00;
        wait_cyc(3);
        checks++;
        if (pad_if.joy_data !== 1'b1 || pad_if.bit_count !== 4'd0 ||
            pad_if.read_done !== 1'b0 || pad_if.latched !== 1'b0) begin
            errors++;
            $display("FAIL reset_values got data=%b cnt=%0d done=%b latched=%b exp 1 0 0 0",
                     pad_if.joy_data, pad_if.bit_count, pad_if.read_done, pad_if.latched);
        end
        rst_n = 1'b1;
        wait_cyc(2);
    endtask

    task automatic test_idle_clock();
        clk_pulse();
        clk_pulse();
        checks++;
        if (pad_if.joy_data !== 1'b1 || pad_if.bit_count !== 4'd0 || pad_if.latched !== 1'b0) begin
            errors++;
            $display("FAIL idle_clock got data=%b cnt=%0d latched=%b exp 1 0 0",
                     pad_if.joy_data, pad_if.bit_count, pad_if.latched);
        end
    endtask

    task automatic test_read();
        logic [7:0] exp_seq;
        int         d0;
        exp_seq = 8'b1111_0110;
        pad_if.buttons = 8'h09;
        d0 = done_cnt;
        strobe_pulse();
        checks++;
        if (pad_if.latched !== 1'b1 || pad_if.bit_count !== 4'd0) begin
            errors++;
            $display("FAIL read_latch got latched=%b cnt=%0d exp 1 0", pad_if.latched, pad_if.bit_count);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (pad_if.joy_data !== exp_seq[k]) begin
                errors++;
                $display("FAIL read_bit%0d got %b exp %b", k, pad_if.joy_data, exp_seq[k]);
            end
            clk_pulse();
        end
        checks++;
        if (pad_if.bit_count !== 4'd8 || pad_if.joy_data !== 1'b1 || (done_cnt - d0) != 1) begin
            errors++;
            $display("FAIL read_end got cnt=%0d data=%b pulses=%0d exp 8 1 1",
                     pad_if.bit_count, pad_if.joy_data, done_cnt - d0);
        end
    endtask

    task automatic test_overread();
        int d0;
        d0 = done_cnt;
        for (int k = 0; k < 10; k++) begin
            clk_pulse();
            checks++;
            if (pad_if.joy_data !== 1'b1 || pad_if.bit_count !== 4'd8) begin
                errors++;
                $display("FAIL overread%0d got data=%b cnt=%0d exp 1 8", k, pad_if.joy_data, pad_if.bit_count);
            end
        end
        checks++;
        if ((done_cnt - d0) != 0) begin
            errors++;
            $display("FAIL overread_pulse got %0d exp 0", done_cnt - d0);
        end
    endtask

    task automatic test_glitch();
        pad_if.buttons = 8'hA5;
        strobe_pulse();
        pad_if.buttons = 8'h00;
        clk_pulse();
        clk_pulse();
        // Two-cycle glitch, shorter than FILTER.
        pad_if.joy_clock = 1'b1;
        wait_cyc(2);
        pad_if.joy_clock = 1'b0;
        wait_cyc(10);
        checks++;
        if (pad_if.bit_count !== 4'd2 || pad_if.joy_data !== 1'b0) begin
            errors++;
            $display("FAIL glitch got cnt=%0d data=%b exp 2 0", pad_if.bit_count, pad_if.joy_data);
        end
        clk_pulse();
        checks++;
        if (pad_if.bit_count !== 4'd3 || pad_if.joy_data !== 1'b1) begin
            errors++;
            $display("FAIL glitch_next got cnt=%0d data=%b exp 3 1", pad_if.bit_count, pad_if.joy_data);
        end
    endtask

    task automatic test_abort();
        int d0;
        pad_if.buttons = 8'h33;
        strobe_pulse();
        for (int k = 0; k < 4; k++) clk_pulse();
        d0 = done_cnt;
        pad_if.buttons = 8'hFF;
        pad_if.joy_strobe = 1'b1;
        wait_cyc(8);
        checks++;
        if (pad_if.bit_count !== 4'd0 || pad_if.joy_data !== 1'b0) begin
            errors++;
            $display("FAIL abort_load got cnt=%0d data=%b exp 0 0", pad_if.bit_count, pad_if.joy_data);
        end
        pad_if.joy_strobe = 1'b0;
        wait_cyc(8);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (pad_if.joy_data !== 1'b0) begin
                errors++;
                $display("FAIL abort_bit%0d got %b exp 0", k, pad_if.joy_data);
            end
            if (k == 0) begin
                checks++;
                if ((done_cnt - d0) != 0) begin
                    errors++;
                    $display("FAIL abort_pulse got %0d exp 0", done_cnt - d0);
                end
            end
            clk_pulse();
        end
        checks++;
        if (pad_if.bit_count !== 4'd8 || (done_cnt - d0) != 1) begin
            errors++;
            $display("FAIL abort_end got cnt=%0d pulses=%0d exp 8 1", pad_if.bit_count, done_cnt - d0);
        end
    endtask

    task automatic test_coincident();
        pad_if.buttons = 8'h06;
        strobe_pulse();
        clk_pulse();
        clk_pulse();
        pad_if.joy_strobe = 1'b1;
        pad_if.joy_clock  = 1'b1;
        wait_cyc(8);
        checks++;
        if (pad_if.bit_count !== 4'd0 || pad_if.joy_data !== 1'b1) begin
            errors++;
            $display("FAIL coincident got cnt=%0d data=%b exp 0 1", pad_if.bit_count, pad_if.joy_data);
        end
        pad_if.joy_strobe = 1'b0;
        pad_if.joy_clock  = 1'b0;
        wait_cyc(8);
        checks++;
        if (pad_if.bit_count !== 4'd0 || pad_if.joy_data !== 1'b1) begin
            errors++;
            $display("FAIL coincident_release got cnt=%0d data=%b exp 0 1", pad_if.bit_count, pad_if.joy_data);
        end
        clk_pulse();
        checks++;
        if (pad_if.bit_count !== 4'd1 || pad_if.joy_data !== 1'b0) begin
            errors++;
            $display("FAIL coincident_shift got cnt=%0d data=%b exp 1 0", pad_if.bit_count, pad_if.joy_data);
        end
    endtask

    task automatic test_reset_mid_read();
        pad_if.buttons = 8'hFF;
        strobe_pulse();
        for (int k = 0; k < 3; k++) clk_pulse();
        rst_n = 1'b0;
        #1;
        checks++;
        if (pad_if.joy_data !== 1'b1 || pad_if.latched !== 1'b0 || pad_if.bit_count !== 4'd0) begin
            errors++;
            $display("FAIL async_reset got data=%b latched=%b cnt=%0d exp 1 0 0",
                     pad_if.joy_data, pad_if.latched, pad_if.bit_count);
        end
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(2);
        clk_pulse();
        clk_pulse();
        checks++;
        if (pad_if.joy_data !== 1'b1 || pad_if.bit_count !== 4'd0 || pad_if.latched !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle got data=%b cnt=%0d latched=%b exp 1 0 0",
                     pad_if.joy_data, pad_if.bit_count, pad_if.latched);
        end
        strobe_pulse();
        checks++;
        if (pad_if.joy_data !== 1'b0 || pad_if.latched !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_load got data=%b latched=%b exp 0 1", pad_if.joy_data, pad_if.latched);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        done_cnt = 0;
        test_reset();
        test_idle_clock();
        test_read();
        test_overread();
        test_glitch();
        test_abort();
        test_coincident();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nes_pad_responder.md
NES_PAD_RESPONDER -- requirements
Module: nes_pad_responder

Interface
REQ-001 Parameter FILTER, default 3, number of consecutive clock cycles a synchronized input must be stable before its filtered value changes; legal range 1..15.
REQ-002 clock  input  1  system clock; every register in the block is clocked on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 joy_strobe  input  1  latch strobe from the NES side; asynchronous to clock.
REQ-005 joy_clock  input  1  shift clock from the NES side; asynchronous to clock.
REQ-006 joy_data  output  1  serial data line, active-low: 0 = pressed; registered.
REQ-007 buttons  input  8  pad state, active-high pressed; bit order 0..7 = A, B, Select, Start, Up, Down, Left, Right.
REQ-008 bit_count  output  4  number of bits shifted since the last latch, 0..8.
REQ-009 read_done  output  1  one-cycle pulse when the 8th bit has been shifted out.
REQ-010 latched  output  1  high once at least one latch has completed since reset.

Function
REQ-011 joy_strobe and joy_clock SHALL each pass through a 2-flop synchronizer, then a stability filter.
REQ-012 Stability filter: the filtered value updates only after the synchronized value differs from it for FILTER consecutive cycles; any reversion restarts the count.
REQ-013 Edge detection SHALL operate on the filtered signals only; glitches shorter than FILTER cycles produce no edge.
REQ-014 State machine states: IDLE (after reset), LOAD (filtered strobe high), SHIFT (strobe low, bit_count<8), DONE (strobe low, bit_count==8).
REQ-015 Any state -> LOAD whenever the filtered strobe is high.
REQ-016 LOAD -> SHIFT on the filtered strobe falling edge; latched is set to 1 on the same cycle.
REQ-017 SHIFT -> DONE when bit_count reaches 8; DONE holds until the next strobe.
REQ-018 In LOAD, the 8-bit shift register SHALL reload from buttons every cycle, bit_count = 0, and joy_data = ~buttons[0] as of the previous cycle.
REQ-019 On a filtered joy_clock rising edge in SHIFT, the register SHALL shift toward bit 0 with 0 filled in at bit 7, and bit_count increments.
REQ-020 joy_data SHALL equal ~shreg[0] in LOAD, SHIFT and DONE, so reads beyond 8 bits return 1 (not pressed).
REQ-021 In IDLE, joy_data = 1.
REQ-022 bit_count SHALL saturate at 8; joy_clock edges in DONE leave the register and count unchanged.
REQ-023 joy_clock edges in LOAD or IDLE SHALL be ignored.
REQ-024 Same-cycle filtered strobe rising edge and joy_clock rising edge: the strobe wins; no shift occurs.
REQ-025 read_done SHALL pulse high for exactly one cycle, on the cycle bit_count transitions 7 -> 8.
REQ-026 A strobe asserted mid-read (bit_count 1..7) SHALL abort the read: the block enters LOAD, bit_count clears, and read_done does not pulse.
REQ-027 Latency: joy_data reflects the new bit 1 cycle after the filtered edge, i.e. 2 + FILTER + 1 cycles after the pin edge.
REQ-028 buttons SHALL be sampled only in LOAD; changes during SHIFT/DONE do not affect the current read.

Reset
REQ-029 While reset_n is low, the block SHALL drive: state IDLE, shift register 0, joy_data 1, bit_count 0, read_done 0, latched 0.
REQ-030 While reset_n is low, synchronizer flops, filtered values and filter counters SHALL all be 0.
REQ-031 Reset asserted mid-read SHALL take effect immediately, asynchronously; after release, the block waits in IDLE for a strobe.

Verification
REQ-032 Scenario: buttons=8'h09, strobe pulse, then 8 clocks -> joy_data sequence 0,1,1,0,1,1,1,1; read_done pulses once; bit_count=8.
REQ-033 Scenario: 10 additional joy_clock pulses after a full read -> joy_data stays 1, bit_count stays 8, no read_done pulse.
REQ-034 Scenario: FILTER=3, 2-cycle glitch on joy_clock during SHIFT -> no shift, bit_count unchanged.
REQ-035 Scenario: strobe re-asserted after 4 bits with buttons=8'hFF -> bit_count=0; after 8 clocks, joy_data reads eight 0s.
REQ-036 Scenario: reset_n pulsed low mid-read -> joy_data=1, latched=0 asynchronously; clock edges ignored until the next strobe.
REQ-037 Scenario: strobe rising edge and joy_clock rising edge coincident -> LOAD entered, no shift, bit_count=0.
